// File: rtl/stall_control_pkg.sv
// stall_control_pkg: shared pipeline decode constants, FSM state and field helpers for stall_control.
package stall_control_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int ALUOP_HI = 6;
    localparam int ALUOP_LO = 2;
    localparam int MD_CNT_W = 6;

    typedef enum logic {RUN, MD_BUSY} state_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] ins);
        return ins[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ins);
        return ins[RD_HI:RD_LO];
    endfunction

    function automatic logic is_lw(input logic [31:0] ins);
        return opcode_of(ins) == OP_LW;
    endfunction

    function automatic logic is_muldiv(input logic [31:0] ins);
        return opcode_of(ins) == OP_ALU &&
               (ins[ALUOP_HI:ALUOP_LO] == ALU_MUL || ins[ALUOP_HI:ALUOP_LO] == ALU_DIV);
    endfunction

endpackage

// File: rtl/stall_control_md_stall_counter.sv
// md_stall_counter: loadable down-counter with zero flag, timing mul/div occupancy.
module md_stall_counter
    import stall_control_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic [MD_CNT_W-1:0] count,
    output logic                zero
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (load) count <= load_val;
        else if (dec && count != '0) count <= count - 1'b1;
    end

    assign zero = count == '0;

endmodule

// File: rtl/stall_control.sv
// stall_control: load-use, mul/div occupancy and branch-squash pipeline controller.
// Optional STALL_PERF_CNT_EN adds a saturating stall-cycle counter (tied to 0 otherwise).
module stall_control
    import stall_control_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      fd_instruction,
    input  logic [31:0]      de_instruction,
    input  logic [31:0]      em_instruction,
    input  logic [2:0]       bypass_A_sig,
    input  logic [2:0]       bypass_B_sig,
    input  logic             flush_req,
    output logic             pc_enable,
    output logic             fd_enable,
    output logic             de_enable,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic             em_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t              state;
    logic [MD_CNT_W-1:0] count;
    logic                cnt_zero, cnt_load, cnt_dec, go_busy, go_run;
    logic [MD_CNT_W-1:0] cnt_val;
    logic                de_md, load_use;
    logic                unused_bits;

    // bypass flags match r0 too, so the lw destination is qualified here
    assign de_md    = is_muldiv(de_instruction);
    assign load_use = is_lw(de_instruction) && rd_of(de_instruction) != 5'd0 &&
                      (bypass_A_sig[0] || bypass_B_sig[0]);
    assign unused_bits = ^{fd_instruction, em_instruction, bypass_A_sig[2:1], bypass_B_sig[2:1]};

    md_stall_counter u_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_comb begin
        pc_enable = 1'b1;
        fd_enable = 1'b1;
        de_enable = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        em_bubble = 1'b0;
        md_busy   = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        go_busy   = 1'b0;
        go_run    = 1'b0;
        if (!reset_n) begin
            {pc_enable, fd_enable, de_enable} = 3'b000;
            {fd_flush, de_bubble, em_bubble}  = 3'b111;
        end else if (state == MD_BUSY) begin
            md_busy = 1'b1;
            if (flush_req) begin
                {fd_flush, de_bubble} = 2'b11;
                cnt_load = 1'b1;
                go_run   = 1'b1;
            end else if (!cnt_zero) begin
                {pc_enable, fd_enable, de_enable} = 3'b000;
                em_bubble = 1'b1;
                cnt_dec   = 1'b1;
            end else begin
                go_run = 1'b1;
            end
        end else if (flush_req) begin
            {fd_flush, de_bubble} = 2'b11;
        end else if (de_md) begin
            {pc_enable, fd_enable, de_enable} = 3'b000;
            em_bubble = 1'b1;
            cnt_load  = 1'b1;
            cnt_val   = MD_CNT_W'(MD_LATENCY - 1);
            go_busy   = 1'b1;
        end else if (load_use) begin
            {pc_enable, fd_enable} = 2'b00;
            de_bubble = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else if (go_busy) state <= MD_BUSY;
        else if (go_run) state <= RUN;
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) stall_cycles <= '0;
        else if (!pc_enable && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_stall_control.sv
// tb_stall_control: table-driven plus sequence checks of stall_control with a scoreboard queue.
module tb_stall_control;

    localparam int LAT = 4;
    localparam int CW  = 32;
`ifdef STALL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // expected output vector order: {pc, fd, de, fd_flush, de_bubble, em_bubble, md_busy}
    localparam logic [6:0] V_RUN  = 7'b1110000;
    localparam logic [6:0] V_LU   = 7'b0010100;
    localparam logic [6:0] V_FL   = 7'b1111100;
    localparam logic [6:0] V_MDE  = 7'b0000010;
    localparam logic [6:0] V_MDB  = 7'b0000011;
    localparam logic [6:0] V_REL  = 7'b1110001;
    localparam logic [6:0] V_MDFL = 7'b1111101;
    localparam logic [6:0] V_RST  = 7'b0001110;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   fd_instruction = '0, de_instruction = '0, em_instruction = '0;
    logic [2:0]    bypass_A_sig = '0, bypass_B_sig = '0;
    logic          flush_req = 1'b0;
    logic          pc_enable, fd_enable, de_enable, fd_flush, de_bubble, em_bubble, md_busy;
    logic [CW-1:0] stall_cycles;
    logic [6:0]    act;

    always #5 clock = ~clock;

    stall_control #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fd_instruction (fd_instruction),
        .de_instruction (de_instruction),
        .em_instruction (em_instruction),
        .bypass_A_sig   (bypass_A_sig),
        .bypass_B_sig   (bypass_B_sig),
        .flush_req      (flush_req),
        .pc_enable      (pc_enable),
        .fd_enable      (fd_enable),
        .de_enable      (de_enable),
        .fd_flush       (fd_flush),
        .de_bubble      (de_bubble),
        .em_bubble      (em_bubble),
        .md_busy        (md_busy),
        .stall_cycles   (stall_cycles)
    );

    assign act = {pc_enable, fd_enable, de_enable, fd_flush, de_bubble, em_bubble, md_busy};

    typedef struct {
        string       name;
        logic [31:0] fd, de;
        logic [2:0]  ba, bb;
        logic        fl;
        logic [6:0]  exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [6:0]  out;
        logic [CW-1:0] sc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_stall = '0;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] al);
        return {op, rd, 15'b0, al, 2'b00};
    endfunction

    task automatic step(input string name, input logic rst, input logic [31:0] fd, input logic [31:0] de,
                        input logic [2:0] ba, input logic [2:0] bb, input logic fl, input logic [6:0] e);
        exp_t x;
        reset_n = rst;
        fd_instruction = fd;
        de_instruction = de;
        em_instruction = fd ^ de;
        bypass_A_sig = ba;
        bypass_B_sig = bb;
        flush_req = fl;
        if (!rst) exp_stall = '0;
        x.name = name;
        x.out = e;
        x.sc = PERF ? exp_stall : '0;
        sb.push_back(x);
        @(negedge clock);
        x = sb.pop_front();
        checks++;
        if (act !== x.out) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", x.name, act, x.out);
        end
        checks++;
        if (stall_cycles !== x.sc) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", x.name, stall_cycles, x.sc);
        end
        if (rst && !x.out[6] && !(&exp_stall)) exp_stall++;
        @(posedge clock);
        #1;
    endtask

    logic [31:0] nop, add, lw5, lw0, lw7, mul, dv;
    vec_t tbl[8];

    initial begin
        nop = mk(5'b00000, 5'd0, 5'b00000);
        add = mk(5'b00000, 5'd6, 5'b00000);
        lw5 = mk(5'b01000, 5'd5, 5'b00000);
        lw0 = mk(5'b01000, 5'd0, 5'b00000);
        lw7 = mk(5'b01000, 5'd7, 5'b00000);
        mul = mk(5'b00000, 5'd3, 5'b00110);
        dv  = mk(5'b00000, 5'd4, 5'b00111);
        tbl[0] = '{"lu_a",        add, lw5, 3'b001, 3'b000, 1'b0, V_LU};
        tbl[1] = '{"lw_r0",       add, lw0, 3'b001, 3'b000, 1'b0, V_RUN};
        tbl[2] = '{"lu_b",        add, lw5, 3'b000, 3'b001, 1'b0, V_LU};
        tbl[3] = '{"lw_em_only",  add, lw5, 3'b010, 3'b000, 1'b0, V_RUN};
        tbl[4] = '{"flush_lu",    add, lw5, 3'b001, 3'b000, 1'b1, V_FL};
        tbl[5] = '{"alu_de",      add, add, 3'b001, 3'b001, 1'b0, V_RUN};
        tbl[6] = '{"flush_only",  add, nop, 3'b000, 3'b000, 1'b1, V_FL};
        tbl[7] = '{"lu_mw_a_de_b",add, lw7, 3'b100, 3'b001, 1'b0, V_LU};

        step("reset", 1'b0, add, lw5, 3'b001, 3'b000, 1'b0, V_RST);
        step("post_reset", 1'b1, add, nop, 3'b000, 3'b000, 1'b0, V_RUN);

        foreach (tbl[i])
            step(tbl[i].name, 1'b1, tbl[i].fd, tbl[i].de, tbl[i].ba, tbl[i].bb, tbl[i].fl, tbl[i].exp);

        step("lu_stall", 1'b1, add, lw5, 3'b001, 3'b000, 1'b0, V_LU);
        step("lu_resume", 1'b1, add, nop, 3'b000, 3'b000, 1'b0, V_RUN);

        step("mul_entry", 1'b1, add, mul, 3'b000, 3'b000, 1'b0, V_MDE);
        for (int k = 0; k < LAT - 1; k++)
            step("mul_busy", 1'b1, add, mul, 3'b000, 3'b000, 1'b0, V_MDB);
        step("mul_release", 1'b1, add, mul, 3'b000, 3'b000, 1'b0, V_REL);
        step("mul_after", 1'b1, add, add, 3'b000, 3'b000, 1'b0, V_RUN);

        step("div_entry", 1'b1, add, dv, 3'b000, 3'b000, 1'b0, V_MDE);
        step("div_busy3", 1'b1, add, dv, 3'b000, 3'b000, 1'b0, V_MDB);
        step("div_flush2", 1'b1, add, dv, 3'b001, 3'b000, 1'b1, V_MDFL);
        step("div_abort_run", 1'b1, add, add, 3'b000, 3'b000, 1'b0, V_RUN);

        step("flush_over_mul", 1'b1, add, mul, 3'b000, 3'b000, 1'b1, V_FL);
        step("flush_stays_run", 1'b1, add, add, 3'b000, 3'b000, 1'b0, V_RUN);

        step("mul_entry2", 1'b1, add, mul, 3'b000, 3'b000, 1'b0, V_MDE);
        step("mul_busy2", 1'b1, add, mul, 3'b000, 3'b000, 1'b0, V_MDB);
        step("reset_mid_busy", 1'b0, add, mul, 3'b000, 3'b000, 1'b0, V_RST);
        step("reset_release", 1'b1, add, add, 3'b000, 3'b000, 1'b0, V_RUN);
        step("mul_entry3", 1'b1, add, mul, 3'b000, 3'b000, 1'b0, V_MDE);
        for (int k = 0; k < LAT - 1; k++)
            step("mul_busy3", 1'b1, add, mul, 3'b000, 3'b000, 1'b0, V_MDB);
        step("mul_release3", 1'b1, add, mul, 3'b000, 3'b000, 1'b0, V_REL);
        step("final_run", 1'b1, add, nop, 3'b000, 3'b000, 1'b0, V_RUN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
